dem_99_00: RTL and testbench

- Two-digit BCD down counter: counts 99 → 00, then wraps back to 99.
- Outputs the units digit (`dv`) and tens digit (`ch`) as 4-bit BCD.
- Also drives a 7-segment pattern for each digit.
- Sits between the system clock domain and a two-digit 7-segment display, acting as a countdown / display source.

---
 rtl/dem_pkg.sv | 26 ++
 rtl/bcd_to_7seg.sv | 33 +++
 rtl/dem_99_00.sv | 62 ++++++
 tb/tb_dem_99_00.sv | 119 +++++++++++
 4 files changed

// File: rtl/dem_pkg.sv
// rtl/dem_pkg.sv - shared BCD digit type, digit limits and 7-segment patterns
package dem_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;
    localparam bcd_t DIGIT_MIN = 4'd0;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic is_valid_digit(input bcd_t d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - BCD digit to 7-segment decoder with selectable polarity
module bcd_to_7seg
    import dem_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_hi;

    // Codes 10-15 blank the digit rather than showing garbage
    always_comb begin
        seg_hi = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_hi = SEG_0;
            4'd1:    seg_hi = SEG_1;
            4'd2:    seg_hi = SEG_2;
            4'd3:    seg_hi = SEG_3;
            4'd4:    seg_hi = SEG_4;
            4'd5:    seg_hi = SEG_5;
            4'd6:    seg_hi = SEG_6;
            4'd7:    seg_hi = SEG_7;
            4'd8:    seg_hi = SEG_8;
            4'd9:    seg_hi = SEG_9;
            default: seg_hi = SEG_BLANK;
        endcase
    end

    assign seg_o = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/dem_99_00.sv
// rtl/dem_99_00.sv - two-digit BCD down counter 99..00 with 7-segment outputs
module dem_99_00
    import dem_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [3:0] dv,
    output logic [3:0] ch,
    output logic [6:0] seg_dv,
    output logic [6:0] seg_ch
);

    bcd_t dv_q, dv_d;
    bcd_t ch_q, ch_d;

    // enable is active-low; an out-of-range digit recovers straight to 99
    always_comb begin
        dv_d = dv_q;
        ch_d = ch_q;
        if (!enable) begin
            if (!is_valid_digit(dv_q) || !is_valid_digit(ch_q)) begin
                dv_d = DIGIT_MAX;
                ch_d = DIGIT_MAX;
            end else if (dv_q != DIGIT_MIN) begin
                dv_d = dv_q - 4'd1;
            end else if (ch_q != DIGIT_MIN) begin
                dv_d = DIGIT_MAX;
                ch_d = ch_q - 4'd1;
            end else begin
                dv_d = DIGIT_MAX;
                ch_d = DIGIT_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q <= DIGIT_MAX;
            ch_q <= DIGIT_MAX;
        end else begin
            dv_q <= dv_d;
            ch_q <= ch_d;
        end
    end

    assign dv = dv_q;
    assign ch = ch_q;

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_dv (
        .bcd_i (dv_q),
        .seg_o (seg_dv)
    );

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ch (
        .bcd_i (ch_q),
        .seg_o (seg_ch)
    );

endmodule

// File: tb/tb_dem_99_00.sv
// tb/tb_dem_99_00.sv - directed self-checking bench for dem_99_00 (both segment polarities)
module tb_dem_99_00;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] dv_l, ch_l, dv_h, ch_h;
    logic [6:0] seg_dv_l, seg_ch_l, seg_dv_h, seg_ch_h;

    int checks = 0;
    int errors = 0;
    int expv;

    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    dem_99_00 #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .reset(reset), .enable(enable),
        .dv(dv_l), .ch(ch_l), .seg_dv(seg_dv_l), .seg_ch(seg_ch_l)
    );

    dem_99_00 #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .reset(reset), .enable(enable),
        .dv(dv_h), .ch(ch_h), .seg_dv(seg_dv_h), .seg_ch(seg_ch_h)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_val(input string tag, input int v);
        chk({tag, ".ch"}, {4'd0, ch_l}, 8'(v / 10));
        chk({tag, ".dv"}, {4'd0, dv_l}, 8'(v % 10));
        chk({tag, ".seg_dv_l"}, {1'b0, seg_dv_l}, {1'b0, ~SEG_TBL[v % 10]});
        chk({tag, ".seg_ch_l"}, {1'b0, seg_ch_l}, {1'b0, ~SEG_TBL[v / 10]});
        chk({tag, ".seg_dv_h"}, {1'b0, seg_dv_h}, {1'b0, SEG_TBL[v % 10]});
        chk({tag, ".seg_ch_h"}, {1'b0, seg_ch_h}, {1'b0, SEG_TBL[v / 10]});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Reset with enable high
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset.ch", {4'd0, ch_l}, 8'd9);
        chk("reset.dv", {4'd0, dv_l}, 8'd9);
        chk("reset.seg_dv", {1'b0, seg_dv_l}, 8'h10);
        chk("reset.seg_ch", {1'b0, seg_ch_l}, 8'h10);
        chk("reset.seg_dv_h", {1'b0, seg_dv_h}, 8'h6F);

        // Hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_val("hold", 99);
        end

        // Units borrow: 98..90 then 89
        enable = 1'b0;
        for (int v = 98; v >= 89; v--) begin
            tick();
            chk_val("borrow", v);
            if (v == 90) chk("borrow.seg0", {1'b0, seg_dv_l}, 8'h40);
        end

        // Full wrap from a fresh 99
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_val("rst2", 99);
        expv = 99;
        for (int i = 0; i < 100; i++) begin
            tick();
            expv = (expv == 0) ? 99 : expv - 1;
            chk_val("wrap", expv);
        end
        chk("wrap.end", 8'(expv), 8'd99);

        // Count down to 57, pause 5 cycles, resume
        for (int i = 0; i < 42; i++) tick();
        chk_val("at57", 57);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_val("pause", 57);
        end
        enable = 1'b0;
        tick();
        chk_val("resume", 56);

        // Reset mid-count at 42 with enable still low
        for (int i = 0; i < 14; i++) tick();
        chk_val("at42", 42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_val("midrst", 99);
        chk("midrst.seg_ch_h", {1'b0, seg_ch_h}, 8'h6F);
        chk("midrst.seg_dv_h", {1'b0, seg_dv_h}, 8'h6F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
